// File: rtl/fft_ram_wr_pkg.sv
// rtl/fft_ram_wr_pkg.sv - shared FFT sizing and run-handshake state encodings
// Used by the RAM writer, the run controller and the spectrum reader.
package fft_ram_wr_pkg;
  localparam int FFT_DW = 16;
  localparam int FFT_N  = 1024;
  localparam int FFT_AW = $clog2(FFT_N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } fft_state_e;
endpackage

// File: rtl/fft_ram_wr_if.sv
// rtl/fft_ram_wr_if.sv - FFT output stream plus spectrum RAM write port
// The slave side consumes the stream and drives the RAM write port.
interface fft_ram_wr_if
  import fft_ram_wr_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int AW = FFT_AW
) ();
  logic              s_data_tvalid;
  logic              s_data_tready;
  logic [2*DW-1:0]   s_data_tdata;
  logic              s_data_tlast;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [2*DW:0]     ram_wdata;

  modport master (
    output s_data_tvalid, s_data_tdata, s_data_tlast,
    input  s_data_tready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  s_data_tvalid, s_data_tdata, s_data_tlast,
    output s_data_tready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/fft_mag_sq.sv
// rtl/fft_mag_sq.sv - two-stage squared-magnitude pipe with valid/addr sideband
// Stage 1 squares each component, stage 2 sums them into an unsigned 2*DW+1 word.
module fft_mag_sq #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  input  logic [AW-1:0]        i_addr,
  output logic                 o_s1_valid,
  output logic                 o_valid,
  output logic [AW-1:0]        o_addr,
  output logic [2*DW:0]        o_data
);
  logic signed [2*DW-1:0] w_re_ext, w_im_ext;
  logic signed [2*DW-1:0] r_re_sq, r_im_sq;
  logic                   r_s1_valid, r_valid;
  logic [AW-1:0]          r_s1_addr, r_addr;
  logic [2*DW:0]          r_data;

  // Sign-extend first so the product of two -2^(DW-1) stays positive in 2*DW bits.
  assign w_re_ext = {{DW{i_re[DW-1]}}, i_re};
  assign w_im_ext = {{DW{i_im[DW-1]}}, i_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_re_sq    <= '0;
      r_im_sq    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_re_sq    <= w_re_ext * w_re_ext;
      r_im_sq    <= w_im_ext * w_im_ext;
      r_s1_valid <= i_valid;
      r_s1_addr  <= i_addr;
      r_valid    <= r_s1_valid;
      r_addr     <= r_s1_addr;
      r_data     <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
    end
  end

  assign o_s1_valid = r_s1_valid;
  assign o_valid    = r_valid;
  assign o_addr     = r_addr;
  assign o_data     = r_data;
endmodule

// File: rtl/fft_ram_wr.sv
// rtl/fft_ram_wr.sv - captures one FFT frame, writes |X|^2 per bin to spectrum RAM
// Beat count alone ends the frame; tlast only feeds the sticky frame_err flag.
module fft_ram_wr
  import fft_ram_wr_pkg::*;
#(
  parameter int DW = FFT_DW,
  parameter int N  = FFT_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fft_valid,
  fft_ram_wr_if.slave      bus,
  output logic             fft_shutdown,
  output logic             busy,
  output logic             frame_err
);
  localparam int AW = $clog2(N);

  fft_state_e    r_state, w_next;
  logic          r_fv_d, r_abort, r_frame_err;
  logic [AW-1:0] r_cnt;
  logic          w_start, w_accept, w_last_beat, w_tready, w_s1_valid;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [2*DW:0] w_wdata;

  assign w_start     = fft_valid & ~r_fv_d;
  assign w_last_beat = (r_cnt == AW'(N - 1));
  assign w_accept    = bus.s_data_tvalid & w_tready;

  always_comb begin
    w_next       = r_state;
    w_tready     = 1'b0;
    busy         = 1'b0;
    fft_shutdown = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Gated by fft_valid so the cycle the run is withdrawn takes no beat.
        w_tready = fft_valid;
        busy     = 1'b1;
        if (!fft_valid)                     w_next = ST_DRAIN;
        else if (w_accept && w_last_beat)   w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Stage 2 lands its final write this cycle, so DONE follows that write.
        if (!w_s1_valid) w_next = r_abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        fft_shutdown = 1'b1;
        w_next       = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_fv_d      <= 1'b0;
      r_cnt       <= '0;
      r_abort     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fv_d  <= fft_valid;
      if (r_state == ST_IDLE && w_start) begin
        r_cnt       <= '0;
        r_abort     <= 1'b0;
        r_frame_err <= 1'b0;
      end
      if (r_state == ST_CAPTURE && !fft_valid) r_abort <= 1'b1;
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        if (bus.s_data_tlast != w_last_beat) r_frame_err <= 1'b1;
      end
    end
  end

  fft_mag_sq #(.DW(DW), .AW(AW)) u_mag (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (w_accept),
    .i_re       (bus.s_data_tdata[DW-1:0]),
    .i_im       (bus.s_data_tdata[2*DW-1:DW]),
    .i_addr     (r_cnt),
    .o_s1_valid (w_s1_valid),
    .o_valid    (w_we),
    .o_addr     (w_addr),
    .o_data     (w_wdata)
  );

  assign bus.s_data_tready = w_tready;
  assign bus.ram_we        = w_we;
  assign bus.ram_addr      = w_addr;
  assign bus.ram_wdata     = w_wdata;
  assign frame_err         = r_frame_err;
endmodule
